// File: rtl/spi_counter.sv
// Free-running up-counter streamed over a write-only SPI mode-0 link, one frame per value.
// Every output is a register, so cs/sclk/sdo only move on rising clk edges (or async reset).
module spi_counter #(
   parameter int WIDTH = 16,
   parameter int DIV   = 2,
   parameter int GAP   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic cs,
   output logic sclk,
   output logic sdo
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SETUP    = 3'd1;
   localparam logic [2:0] SHIFT_HI = 3'd2;
   localparam logic [2:0] SHIFT_LO = 3'd3;
   localparam logic [2:0] GAP_ST   = 3'd4;

   localparam int TMAX = (DIV > GAP) ? DIV : GAP;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam int BW   = $clog2(WIDTH);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             cs_q, cs_d;
   logic             sclk_q, sclk_d;
   logic             sdo_q, sdo_d;

   logic divDone;
   logic gapDone;
   logic lastBit;

   assign divDone = (timer_q == TW'(DIV - 1));
   assign gapDone = (timer_q == TW'(GAP - 1));
   assign lastBit = (bit_q == BW'(WIDTH - 1));

   // The frame word is captured into shift_q at frame start so counting never disturbs it.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shift_d = shift_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      sdo_d   = sdo_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SETUP;
               shift_d = count_q;
               count_d = count_q + 1'b1;
               cs_d    = 1'b0;
               sdo_d   = count_q[WIDTH-1];
               timer_d = '0;
               bit_d   = '0;
            end
         end
         SETUP: begin
            if (divDone) begin
               timer_d = '0;
               sclk_d  = 1'b1;
               state_d = SHIFT_HI;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (divDone) begin
               timer_d = '0;
               sclk_d  = 1'b0;
               state_d = SHIFT_LO;
               if (!lastBit) begin
                  shift_d = shift_q << 1;
                  sdo_d   = shift_q[WIDTH-2];
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         SHIFT_LO: begin
            if (divDone) begin
               timer_d = '0;
               if (lastBit) begin
                  cs_d    = 1'b1;
                  sdo_d   = 1'b0;
                  state_d = GAP_ST;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  sclk_d  = 1'b1;
                  state_d = SHIFT_HI;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GAP_ST: begin
            if (gapDone) begin
               timer_d = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         shift_q <= '0;
         timer_q <= '0;
         bit_q   <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         sdo_q   <= sdo_d;
      end
   end

   assign cs   = cs_q;
   assign sclk = sclk_q;
   assign sdo  = sdo_q;

endmodule

// File: tb/tb_spi_counter.sv
// Bench for spi_counter: a frame-position model checked every cycle, plus a bus decoder
// whose recovered words and frame lengths are compared with hand-computed values.
module tb_spi_counter;

   localparam int W     = 16;
   localparam int DIV   = 2;
   localparam int GAP   = 4;
   localparam int CSLOW = DIV + 2 * DIV * W;

   logic clk = 1'b0;
   logic rst_n, enable, cs, sclk, sdo;
   logic rst4_n, enable4, cs4, sclk4, sdo4;

   int checks = 0;
   int failures = 0;

   spi_counter #(.WIDTH(W), .DIV(DIV), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cs(cs), .sclk(sclk), .sdo(sdo)
   );

   spi_counter #(.WIDTH(4), .DIV(DIV), .GAP(GAP)) dut4 (
      .clk(clk), .rst_n(rst4_n), .enable(enable4), .cs(cs4), .sclk(sclk4), .sdo(sdo4)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected bus levels from the position inside the frame (p<0 means no frame).
   function automatic void expOut(input int p, input logic [W-1:0] w,
                                  output logic c, output logic s, output logic d);
      int q, b;
      c = 1'b1; s = 1'b0; d = 1'b0;
      if (p >= 0 && p < CSLOW) begin
         c = 1'b0;
         if (p < DIV) begin
            d = w[W-1];
         end else begin
            q = p - DIV;
            b = q / (2 * DIV);
            s = ((q % (2 * DIV)) < DIV);
            if (s) d = w[W-1-b];
            else   d = (b < W - 1) ? w[W-2-b] : w[0];
         end
      end
   endfunction

   int mPos = -1;
   logic [W-1:0] mCount = '0;
   logic [W-1:0] mWord = '0;
   int cycle = 0;
   int lowCnt = 0;
   logic prevCs = 1'b1;
   int lows[$];
   int starts[$];

   always @(posedge clk) begin
      logic ec, es, ed;
      cycle++;
      if (!rst_n) begin
         mPos = -1;
         mCount = '0;
      end else if (mPos < 0) begin
         if (enable) begin
            mPos = 0;
            mWord = mCount;
            mCount = mCount + 1'b1;
         end
      end else if (mPos == CSLOW + GAP - 1) begin
         mPos = -1;
      end else begin
         mPos++;
      end
      #1;
      expOut(mPos, mWord, ec, es, ed);
      checkOutput("cyc_cs", {31'd0, cs}, {31'd0, ec});
      checkOutput("cyc_sclk", {31'd0, sclk}, {31'd0, es});
      checkOutput("cyc_sdo", {31'd0, sdo}, {31'd0, ed});
      if (cs === 1'b0) lowCnt++;
      else if (lowCnt > 0) begin
         lows.push_back(lowCnt);
         lowCnt = 0;
      end
      if (prevCs === 1'b1 && cs === 1'b0) starts.push_back(cycle);
      prevCs = cs;
   end

   logic [W-1:0] decWord = '0;
   int curBits = 0;
   int sclkEdges = 0;
   logic [W-1:0] words[$];
   int bitsQ[$];

   always @(posedge sclk or posedge cs or negedge rst_n) begin
      if (!rst_n || cs) begin
         if (rst_n && curBits > 0) begin
            words.push_back(decWord);
            bitsQ.push_back(curBits);
         end
         curBits <= 0;
         decWord <= '0;
      end else begin
         decWord <= {decWord[W-2:0], sdo};
         curBits <= curBits + 1;
         sclkEdges <= sclkEdges + 1;
      end
   end

   logic [3:0] decWord4 = '0;
   int curBits4 = 0;
   logic [3:0] words4[$];
   int bitsQ4[$];

   always @(posedge sclk4 or posedge cs4 or negedge rst4_n) begin
      if (!rst4_n || cs4) begin
         if (rst4_n && curBits4 > 0) begin
            words4.push_back(decWord4);
            bitsQ4.push_back(curBits4);
         end
         curBits4 <= 0;
         decWord4 <= '0;
      end else begin
         decWord4 <= {decWord4[2:0], sdo4};
         curBits4 <= curBits4 + 1;
      end
   end

   task automatic applyStimulus(input logic en, input int n);
      @(negedge clk);
      enable = en;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clearQueues();
      words.delete();
      bitsQ.delete();
      lows.delete();
      starts.delete();
   endtask

   task automatic waitWords(input int n, input int budget, input string name);
      int k = 0;
      while (words.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(name, {31'd0, (words.size() >= n)}, 32'd1);
   endtask

   task automatic waitBits(input int n, input int budget, input string name);
      int k = 0;
      while (curBits < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(name, {31'd0, (curBits >= n)}, 32'd1);
   endtask

   function automatic logic [31:0] wordAt(input int i);
      return (i < words.size()) ? {16'd0, words[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic int bitsAt(input int i);
      return (i < bitsQ.size()) ? bitsQ[i] : -1;
   endfunction

   function automatic int lowAt(input int i);
      return (i < lows.size()) ? lows[i] : -1;
   endfunction

   initial begin
      int e0, k;
      rst_n = 1'b0; enable = 1'b0;
      rst4_n = 1'b0; enable4 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_cs", {31'd0, cs}, 32'd1);
      checkOutput("reset_sclk", {31'd0, sclk}, 32'd0);
      checkOutput("reset_sdo", {31'd0, sdo}, 32'd0);
      rst_n = 1'b1;

      $display("[TB] test 1: idle with enable low");
      e0 = sclkEdges;
      applyStimulus(1'b0, 20);
      checkOutput("t1_sclk_edges", sclkEdges - e0, 32'd0);
      checkOutput("t1_cs_idle", {31'd0, cs}, 32'd1);

      $display("[TB] test 2: single frame from a 65-cycle enable");
      clearQueues();
      applyStimulus(1'b1, 65);
      applyStimulus(1'b0, 150);
      checkOutput("t2_frames", words.size(), 32'd1);
      checkOutput("t2_word", wordAt(0), 32'h0000);
      checkOutput("t2_bits", bitsAt(0), 32'd16);
      checkOutput("t2_cs_low", lowAt(0), 32'd66);

      $display("[TB] test 3: four back-to-back frames");
      doReset();
      clearQueues();
      @(negedge clk);
      enable = 1'b1;
      waitWords(4, 400, "t3_timeout");
      enable = 1'b0;
      applyStimulus(1'b0, 100);
      checkOutput("t3_frames", words.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t3_word", wordAt(i), i);
         checkOutput("t3_cs_low", lowAt(i), 32'd66);
      end
      for (int i = 1; i < 4; i++)
         checkOutput("t3_period", (i < starts.size()) ? starts[i] - starts[i-1] : -1, 32'd71);

      $display("[TB] test 4: enable dropped mid-frame");
      doReset();
      clearQueues();
      @(negedge clk);
      enable = 1'b1;
      waitBits(8, 200, "t4_timeout");
      enable = 1'b0;
      applyStimulus(1'b0, 150);
      checkOutput("t4_frames", words.size(), 32'd1);
      checkOutput("t4_word", wordAt(0), 32'h0000);
      checkOutput("t4_bits", bitsAt(0), 32'd16);
      clearQueues();
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 150);
      checkOutput("t4_pulse_frames", words.size(), 32'd1);
      checkOutput("t4_pulse_word", wordAt(0), 32'h0001);

      $display("[TB] test 5: 4-bit build wraps after 0xF");
      @(negedge clk);
      rst4_n = 1'b1;
      enable4 = 1'b1;
      k = 0;
      while (words4.size() < 17 && k < 600) begin
         @(negedge clk);
         k++;
      end
      enable4 = 1'b0;
      checkOutput("t5_timeout", {31'd0, (words4.size() >= 17)}, 32'd1);
      for (int i = 0; i < 17; i++) begin
         checkOutput("t5_word", (i < words4.size()) ? {28'd0, words4[i]} : 32'hDEAD_BEEF, i % 16);
         checkOutput("t5_bits", (i < bitsQ4.size()) ? bitsQ4[i] : -1, 32'd4);
      end

      $display("[TB] test 6: reset asserted during shift");
      doReset();
      clearQueues();
      @(negedge clk);
      enable = 1'b1;
      waitBits(3, 200, "t6_timeout");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_abort_cs", {31'd0, cs}, 32'd1);
      checkOutput("t6_abort_sclk", {31'd0, sclk}, 32'd0);
      checkOutput("t6_abort_sdo", {31'd0, sdo}, 32'd0);
      repeat (2) @(negedge clk);
      clearQueues();
      rst_n = 1'b1;
      waitWords(1, 200, "t6_frame_timeout");
      enable = 1'b0;
      checkOutput("t6_word", wordAt(0), 32'h0000);
      checkOutput("t6_bits", bitsAt(0), 32'd16);
      applyStimulus(1'b0, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
